mem_bus_arbiter: RTL and testbench

Shares the single 16-bit external memory bus between two masters: the instruction prefetcher (port A) and the LoadStore data unit (port B).
- Grants one master at a time and holds the grant until the bus acks.
- Data port has priority; a starvation counter guarantees instruction-fetch progress.
- Sits between the core's two bus masters and the top-level memory interface.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_starve_counter.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    MASTER_A = 1'b0,
    MASTER_B = 1'b1
  } master_t;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Saturating starvation counter: counts data-port wins while the
// instruction port is kept waiting, and flags when the limit is reached.
module mem_arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int                   LIMIT_INT = STARVE_LIMIT;
  localparam logic [ARB_CNT_W-1:0] LIMIT     = LIMIT_INT[ARB_CNT_W-1:0];

  logic [ARB_CNT_W-1:0] r_count;

  // Clear has precedence; increment stops once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single 16-bit external memory bus between the instruction
// prefetcher (port A) and the LoadStore unit (port B). The data port has
// priority; a starvation counter forces an instruction grant after
// STARVE_LIMIT consecutive data grants while A waits. Every grant is
// followed by at least one IDLE cycle.
// Optional macro MEM_ARB_STATS_EN adds per-master wait-cycle counters.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] a_m_addr,
  output logic [15:0] a_m_data_in,
  input  logic        a_m_access,
  output logic        a_m_ack,
  input  logic [19:1] b_m_addr,
  output logic [15:0] b_m_data_in,
  input  logic [15:0] b_m_data_out,
  input  logic        b_m_access,
  output logic        b_m_ack,
  input  logic        b_m_wr_en,
  input  logic [1:0]  b_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] a_wait_cycles,
  output logic [15:0] b_wait_cycles
`endif
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  master_t    w_idleWinner;
  logic       w_idleRequest;
  logic       w_starveHit;
  logic       w_starveInc;
  logic       w_starveClr;

  mem_arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_starveInc),
    .i_clr     (w_starveClr),
    .o_at_limit(w_starveHit)
  );

  // State register; reset drops any grant in the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Arbitration in IDLE and release of the current grant on ack or abort.
  always_comb begin
    w_nextState   = r_state;
    w_idleWinner  = MASTER_B;
    w_idleRequest = a_m_access || b_m_access;
    if (b_m_access && !(a_m_access && w_starveHit)) begin
      w_idleWinner = MASTER_B;
    end else if (a_m_access) begin
      w_idleWinner = MASTER_A;
    end
    case (r_state)
      IDLE: begin
        if (w_idleRequest) begin
          w_nextState = (w_idleWinner == MASTER_B) ? GRANT_B : GRANT_A;
        end
      end
      GRANT_A: begin
        if (q_m_ack || !a_m_access) begin
          w_nextState = IDLE;
        end
      end
      GRANT_B: begin
        if (q_m_ack || !b_m_access) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_starveInc = (r_state == IDLE) && (w_nextState == GRANT_B) && a_m_access;
  assign w_starveClr = (r_state == IDLE) && ((w_nextState == GRANT_A) || !a_m_access);

  // Route the granted master onto the memory bus; everything idles at zero.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_data_out = '0;
    a_m_ack      = 1'b0;
    b_m_ack      = 1'b0;
    case (r_state)
      GRANT_A: begin
        q_m_access  = a_m_access;
        q_m_addr    = a_m_addr;
        q_m_bytesel = 2'b11;
        a_m_ack     = q_m_ack;
      end
      GRANT_B: begin
        q_m_access   = b_m_access;
        q_m_addr     = b_m_addr;
        q_m_wr_en    = b_m_wr_en;
        q_m_bytesel  = b_m_bytesel;
        q_m_data_out = b_m_data_out;
        b_m_ack      = q_m_ack;
      end
      default: begin
      end
    endcase
  end

  assign a_m_data_in = q_m_data_in;
  assign b_m_data_in = q_m_data_in;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_aWait;
  logic [15:0] r_bWait;

  // Saturating count of cycles each master requests without owning the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aWait <= '0;
      r_bWait <= '0;
    end else begin
      if (a_m_access && (r_state != GRANT_A) && (r_aWait != 16'hFFFF)) begin
        r_aWait <= r_aWait + 16'd1;
      end
      if (b_m_access && (r_state != GRANT_B) && (r_bWait != 16'hFFFF)) begin
        r_bWait <= r_bWait + 16'd1;
      end
    end
  end

  assign a_wait_cycles = r_aWait;
  assign b_wait_cycles = r_bWait;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a read-data scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Build with MEM_ARB_STATS_EN to also check wait counters.
module tb_mem_bus_arbiter;

  typedef struct {
    logic        isA;
    logic [15:0] data;
  } sbEntry_t;

  logic        clk;
  logic        reset;
  logic [19:1] a_m_addr;
  logic [15:0] a_m_data_in;
  logic        a_m_access;
  logic        a_m_ack;
  logic [19:1] b_m_addr;
  logic [15:0] b_m_data_in;
  logic [15:0] b_m_data_out;
  logic        b_m_access;
  logic        b_m_ack;
  logic        b_m_wr_en;
  logic [1:0]  b_m_bytesel;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] a_wait_cycles;
  logic [15:0] b_wait_cycles;
`endif

  int compared   = 0;
  int mismatched = 0;
  sbEntry_t sbQueue[$];

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_m_addr    (a_m_addr),
    .a_m_data_in (a_m_data_in),
    .a_m_access  (a_m_access),
    .a_m_ack     (a_m_ack),
    .b_m_addr    (b_m_addr),
    .b_m_data_in (b_m_data_in),
    .b_m_data_out(b_m_data_out),
    .b_m_access  (b_m_access),
    .b_m_ack     (b_m_ack),
    .b_m_wr_en   (b_m_wr_en),
    .b_m_bytesel (b_m_bytesel),
    .q_m_addr    (q_m_addr),
    .q_m_data_in (q_m_data_in),
    .q_m_data_out(q_m_data_out),
    .q_m_access  (q_m_access),
    .q_m_ack     (q_m_ack),
    .q_m_wr_en   (q_m_wr_en),
    .q_m_bytesel (q_m_bytesel)
`ifdef MEM_ARB_STATS_EN
    ,
    .a_wait_cycles(a_wait_cycles),
    .b_wait_cycles(b_wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic isA, input logic [15:0] data);
    sbEntry_t e;
    e.isA  = isA;
    e.data = data;
    sbQueue.push_back(e);
  endtask

  // Scoreboard: every ack seen must match the next expected completion.
  always @(negedge clk) begin
    if (a_m_ack || b_m_ack) begin
      sbEntry_t e;
      checkOutput("sb_expected_ack", (sbQueue.size() != 0), 1);
      if (sbQueue.size() != 0) begin
        e = sbQueue.pop_front();
        checkOutput("sb_a_ack", a_m_ack, e.isA);
        checkOutput("sb_b_ack", b_m_ack, !e.isA);
        checkOutput("sb_rdata", e.isA ? a_m_data_in : b_m_data_in, e.data);
      end
    end
  end

  initial begin
    int starve;
    logic expA;

    reset        = 1'b1;
    a_m_addr     = '0;
    a_m_access   = 1'b0;
    b_m_addr     = '0;
    b_m_data_out = '0;
    b_m_access   = 1'b0;
    b_m_wr_en    = 1'b0;
    b_m_bytesel  = 2'b00;
    q_m_data_in  = '0;
    q_m_ack      = 1'b0;
    repeat (2) applyStimulus();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_q_access", q_m_access, 0);
    checkOutput("rst_q_addr", q_m_addr, 0);
    checkOutput("rst_q_bytesel", q_m_bytesel, 0);
    checkOutput("rst_acks", {a_m_ack, b_m_ack}, 0);

    // A alone: one cycle to the bus, read-only lanes forced
    applyStimulus();
    a_m_access = 1'b1;
    a_m_addr   = 19'h12345;
    @(negedge clk);
    checkOutput("t1_not_yet", q_m_access, 0);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h1111;
    pushExpect(1'b1, 16'h1111);
    @(negedge clk);
    checkOutput("t1_q_access", q_m_access, 1);
    checkOutput("t1_q_addr", q_m_addr, 19'h12345);
    checkOutput("t1_wr_en", q_m_wr_en, 0);
    checkOutput("t1_bytesel", q_m_bytesel, 2'b11);
    checkOutput("t1_data_out", q_m_data_out, 0);
    applyStimulus();
    q_m_ack    = 1'b0;
    a_m_access = 1'b0;
    @(negedge clk);
    checkOutput("t1_idle", q_m_access, 0);

    // A and B together: B write wins, then A after an IDLE cycle
    applyStimulus();
    a_m_access   = 1'b1;
    a_m_addr     = 19'h00AAA;
    b_m_access   = 1'b1;
    b_m_addr     = 19'h54321;
    b_m_wr_en    = 1'b1;
    b_m_data_out = 16'hBEEF;
    b_m_bytesel  = 2'b01;
    @(negedge clk);
    checkOutput("t2_not_yet", q_m_access, 0);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h2222;
    pushExpect(1'b0, 16'h2222);
    @(negedge clk);
    checkOutput("t2_b_addr", q_m_addr, 19'h54321);
    checkOutput("t2_b_data_out", q_m_data_out, 16'hBEEF);
    checkOutput("t2_b_wr_en", q_m_wr_en, 1);
    checkOutput("t2_b_bytesel", q_m_bytesel, 2'b01);
    applyStimulus();
    q_m_ack    = 1'b0;
    b_m_access = 1'b0;
    b_m_wr_en  = 1'b0;
    @(negedge clk);
    checkOutput("t2_idle_gap", q_m_access, 0);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h3333;
    pushExpect(1'b1, 16'h3333);
    @(negedge clk);
    checkOutput("t2_a_addr", q_m_addr, 19'h00AAA);
    checkOutput("t2_a_wr_en", q_m_wr_en, 0);
    applyStimulus();
    q_m_ack    = 1'b0;
    a_m_access = 1'b0;
    @(negedge clk);

    // Starvation: A held, B continuous -> B x4, A, then B x4, A
    applyStimulus();
    a_m_access  = 1'b1;
    a_m_addr    = 19'h0F0F0;
    b_m_access  = 1'b1;
    b_m_addr    = 19'h70707;
    b_m_bytesel = 2'b11;
    starve = 0;
    for (int i = 0; i < 10; i++) begin
      expA = (starve == 4);
      if (expA) starve = 0;
      else if (starve < 4) starve = starve + 1;
      applyStimulus();
      q_m_ack     = 1'b1;
      q_m_data_in = 16'h4000 + 16'(i);
      pushExpect(expA, 16'h4000 + 16'(i));
      @(negedge clk);
      checkOutput($sformatf("t3_grant%0d_addr", i), q_m_addr,
                  expA ? 19'h0F0F0 : 19'h70707);
      applyStimulus();
      q_m_ack = 1'b0;
      if (i == 9) begin
        a_m_access = 1'b0;
        b_m_access = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("t3_gap%0d", i), q_m_access, 0);
    end

    // Unaligned B read: two grants with an IDLE cycle in between
    applyStimulus();
    b_m_access = 1'b1;
    b_m_addr   = 19'h00100;
    @(negedge clk);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hA1A1;
    pushExpect(1'b0, 16'hA1A1);
    @(negedge clk);
    checkOutput("t4_first_addr", q_m_addr, 19'h00100);
    applyStimulus();
    q_m_ack  = 1'b0;
    b_m_addr = 19'h00101;
    @(negedge clk);
    checkOutput("t4_mid_idle", q_m_access, 0);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hB2B2;
    pushExpect(1'b0, 16'hB2B2);
    @(negedge clk);
    checkOutput("t4_second_addr", q_m_addr, 19'h00101);
    applyStimulus();
    q_m_ack    = 1'b0;
    b_m_access = 1'b0;
    @(negedge clk);

    // Reset during GRANT_B, then a late ack that must be ignored
    applyStimulus();
    b_m_access = 1'b1;
    b_m_addr   = 19'h33333;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("t5_granted", q_m_access, 1);
    applyStimulus();
    reset = 1'b1;
    @(negedge clk);
    applyStimulus();
    reset      = 1'b0;
    b_m_access = 1'b0;
    q_m_ack    = 1'b1;
    @(negedge clk);
    checkOutput("t5_dropped", q_m_access, 0);
    checkOutput("t5_late_acks", {a_m_ack, b_m_ack}, 0);
    applyStimulus();
    q_m_ack = 1'b0;
    @(negedge clk);
    checkOutput("t5_stay_idle", q_m_access, 0);

`ifdef MEM_ARB_STATS_EN
    // A waits IDLE + GRANT_B + IDLE = 3 cycles; B waits its IDLE cycle
    applyStimulus();
    a_m_access = 1'b1;
    a_m_addr   = 19'h00011;
    b_m_access = 1'b1;
    b_m_addr   = 19'h00022;
    @(negedge clk);
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h5555;
    pushExpect(1'b0, 16'h5555);
    @(negedge clk);
    applyStimulus();
    q_m_ack    = 1'b0;
    b_m_access = 1'b0;
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkOutput("t6_a_wait", a_wait_cycles, 3);
    checkOutput("t6_b_wait", b_wait_cycles, 1);
    q_m_ack     = 1'b0;
    applyStimulus();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h6666;
    pushExpect(1'b1, 16'h6666);
    @(negedge clk);
    applyStimulus();
    q_m_ack    = 1'b0;
    a_m_access = 1'b0;
    @(negedge clk);
`endif

    repeat (2) applyStimulus();
    @(negedge clk);
    checkOutput("sb_drained", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
